// File: rtl/deconv_col_scheduler_if.sv
// Handshake bundle between the column scheduler and the layer controller,
// weight FIFO and deconvolution op top.
interface deconv_col_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             i_start;
  logic             i_abort;
  logic             o_wcol_rd;
  logic             i_wcol_done;
  logic             o_fifo_loop;
  logic             i_loop_fin;
  logic             i_fmap_valid;
  logic             o_fmap_rdy;
  logic             o_load_ip;
  logic             i_op_valid;
  logic             o_new_chnl;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_chnl_idx;
  logic [CNT_W-1:0] o_fcol_idx;
  logic [CNT_W-1:0] o_wcol_idx;

  modport master (
    input  i_start, i_abort, i_wcol_done, i_loop_fin, i_fmap_valid, i_op_valid,
    output o_wcol_rd, o_fifo_loop, o_fmap_rdy, o_load_ip, o_new_chnl,
           o_busy, o_done, o_chnl_idx, o_fcol_idx, o_wcol_idx
  );

  modport slave (
    output i_start, i_abort, i_wcol_done, i_loop_fin, i_fmap_valid, i_op_valid,
    input  o_wcol_rd, o_fifo_loop, o_fmap_rdy, o_load_ip, o_new_chnl,
           o_busy, o_done, o_chnl_idx, o_fcol_idx, o_wcol_idx
  );
endinterface

// File: rtl/deconv_col_scheduler.sv
// Sequences one deconvolution layer pass: per channel and feature column it
// replays every kernel weight column, loads the input column, then waits for the output.
module deconv_col_scheduler #(
  parameter int WEIGHT_SIZE  = 5,
  parameter int FEATURE_SIZE = 8,
  parameter int N_CHANNEL    = 4,
  parameter int CNT_W        = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  deconv_col_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ_W    = 3'd1,
    S_WAIT_W   = 3'd2,
    S_LOAD_IP  = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_LOOP     = 3'd5,
    S_NEXT_CH  = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(WEIGHT_SIZE - 1);
  localparam logic [CNT_W-1:0] F_LAST   = CNT_W'(FEATURE_SIZE - 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(N_CHANNEL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e           state_q;
  logic [CNT_W-1:0] chnl_q;
  logic [CNT_W-1:0] fcol_q;
  logic [CNT_W-1:0] wcol_q;
  logic             wcol_rd_q;
  logic             fifo_loop_q;
  logic             load_ip_q;
  logic             new_chnl_q;
  logic             busy_q;
  logic             done_q;
  logic             fmap_xfer;

  // Ready is a pure decode of the state so the input buffer sees it without a cycle of lag.
  assign bus.o_fmap_rdy = (state_q == S_LOAD_IP);
  assign fmap_xfer      = (state_q == S_LOAD_IP) && bus.i_fmap_valid;

  assign bus.o_wcol_rd   = wcol_rd_q;
  assign bus.o_fifo_loop = fifo_loop_q;
  assign bus.o_load_ip   = load_ip_q;
  assign bus.o_new_chnl  = new_chnl_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_chnl_idx  = chnl_q;
  assign bus.o_fcol_idx  = fcol_q;
  assign bus.o_wcol_idx  = wcol_q;

  // Pass sequencer; each strobe is raised on the transition into the state it belongs to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      chnl_q      <= CNT_ZERO;
      fcol_q      <= CNT_ZERO;
      wcol_q      <= CNT_ZERO;
      wcol_rd_q   <= 1'b0;
      fifo_loop_q <= 1'b0;
      load_ip_q   <= 1'b0;
      new_chnl_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.i_abort) begin
      state_q     <= S_IDLE;
      chnl_q      <= CNT_ZERO;
      fcol_q      <= CNT_ZERO;
      wcol_q      <= CNT_ZERO;
      wcol_rd_q   <= 1'b0;
      fifo_loop_q <= 1'b0;
      load_ip_q   <= 1'b0;
      new_chnl_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wcol_rd_q   <= 1'b0;
      fifo_loop_q <= 1'b0;
      load_ip_q   <= 1'b0;
      new_chnl_q  <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            busy_q    <= 1'b1;
            chnl_q    <= CNT_ZERO;
            fcol_q    <= CNT_ZERO;
            wcol_q    <= CNT_ZERO;
            wcol_rd_q <= 1'b1;
            state_q   <= S_REQ_W;
          end
        end
        S_REQ_W: begin
          state_q <= S_WAIT_W;
        end
        S_WAIT_W: begin
          if (bus.i_wcol_done) begin
            if (wcol_q < W_LAST) begin
              wcol_q    <= wcol_q + CNT_ONE;
              wcol_rd_q <= 1'b1;
              state_q   <= S_REQ_W;
            end else begin
              wcol_q  <= CNT_ZERO;
              state_q <= S_LOAD_IP;
            end
          end
        end
        S_LOAD_IP: begin
          if (fmap_xfer) begin
            load_ip_q <= 1'b1;
            state_q   <= S_WAIT_OUT;
          end
        end
        S_WAIT_OUT: begin
          if (bus.i_op_valid) begin
            if (fcol_q < F_LAST) begin
              fcol_q      <= fcol_q + CNT_ONE;
              fifo_loop_q <= 1'b1;
              state_q     <= S_LOOP;
            end else begin
              fcol_q     <= CNT_ZERO;
              new_chnl_q <= 1'b1;
              state_q    <= S_NEXT_CH;
            end
          end
        end
        S_LOOP: begin
          // The rewind may complete in the same cycle the loop strobe is high.
          if (bus.i_loop_fin) begin
            wcol_rd_q <= 1'b1;
            state_q   <= S_REQ_W;
          end
        end
        S_NEXT_CH: begin
          if (chnl_q < C_LAST) begin
            chnl_q    <= chnl_q + CNT_ONE;
            wcol_rd_q <= 1'b1;
            state_q   <= S_REQ_W;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
